// File: rtl/data_bram_streamer_pkg.sv
// Shared types and constants for the data BRAM streamer.
package data_bram_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } streamer_state_t;

  localparam int STREAMER_FIFO_DEPTH   = 4;
  localparam int STREAMER_BRAM_LATENCY = 1;
  localparam int STREAMER_CNT_W        = $clog2(STREAMER_FIFO_DEPTH + 1);

endpackage

// File: rtl/data_bram_streamer_fifo.sv
// Prefetch FIFO of {tlast, tdata}; entry 0 is always the head so the stream
// outputs come straight from registers. Push and pop may share a cycle.
module data_bram_streamer_fifo
  import data_bram_streamer_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          head,
  output logic                      valid,
  output logic [STREAMER_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(STREAMER_FIFO_DEPTH);

  logic [WIDTH-1:0]          mem   [STREAMER_FIFO_DEPTH];
  logic [WIDTH-1:0]          mem_n [STREAMER_FIFO_DEPTH];
  logic [STREAMER_CNT_W-1:0] count_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mem_n   = mem;
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      if (pop && valid) begin
        for (int i = 0; i < STREAMER_FIFO_DEPTH - 1; i++) mem_n[i] = mem[i+1];
        count_n = count - STREAMER_CNT_W'(1);
      end
      if (push && (count_n < STREAMER_CNT_W'(STREAMER_FIFO_DEPTH))) begin
        mem_n[count_n[PTR_W-1:0]] = din;
        count_n = count_n + STREAMER_CNT_W'(1);
      end
    end
  end

  // NOTE: the storage is reset too, because the head entry drives m_tdata/m_tlast, which must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STREAMER_FIFO_DEPTH; i++) mem[i] <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
      mem   <= mem_n;
      count <= count_n;
      valid <= (count_n != '0);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/data_bram_streamer.sv
// Streams a BRAM window out as AXI4-Stream with a 4-word prefetch credit.
// Looped playback is compiled in only with DATA_BRAM_STREAMER_LOOP_EN defined.
module data_bram_streamer
  import data_bram_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  loop_en,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int IW  = ADDR_WIDTH + 1;
  localparam int LAT = STREAMER_BRAM_LATENCY;

  streamer_state_t           state, state_n;
  logic [ADDR_WIDTH-1:0]     base_q, bram_addr_n;
  logic [IW-1:0]             len_q, rd_idx, rd_idx_n;
  logic                      bram_en_n, bram_last, bram_last_n, done_n, latch;
  logic [LAT-1:0]            rd_vld_sr, rd_last_sr;
  logic                      pop, push, flush, credit_ok, loop_start;
  logic [DATA_WIDTH:0]       head;
  logic [STREAMER_CNT_W-1:0] fifo_count;
  logic [3:0]                ahead;

`ifdef DATA_BRAM_STREAMER_LOOP_EN
  logic loop_q;
  assign loop_start = loop_en;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign loop_start     = 1'b0;
`endif

  assign pop   = m_tvalid & m_tready;
  assign push  = rd_vld_sr[LAT-1];
  assign flush = abort && (state != IDLE);

  // Words buffered or on their way after this cycle's pop; the new read must fit too.
  assign ahead     = 4'(fifo_count) - 4'(pop) + 4'(bram_en) + 4'($countones(rd_vld_sr));
  assign credit_ok = ahead < 4'(STREAMER_FIFO_DEPTH);

  always_comb begin
    state_n     = state;
    bram_en_n   = 1'b0;
    bram_addr_n = bram_addr;
    bram_last_n = 1'b0;
    rd_idx_n    = rd_idx;
    done_n      = 1'b0;
    latch       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_n = 1'b1;
          end else begin
            latch       = 1'b1;
            bram_en_n   = 1'b1;
            bram_addr_n = base_addr;
            bram_last_n = (length == IW'(1));
            if (bram_last_n && !loop_start) begin
              state_n  = DRAIN;
              rd_idx_n = '0;
            end else begin
              state_n  = RUN;
              rd_idx_n = bram_last_n ? '0 : IW'(1);
            end
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (credit_ok) begin
          bram_en_n   = 1'b1;
          bram_addr_n = base_q + rd_idx[ADDR_WIDTH-1:0];
          bram_last_n = (rd_idx == len_q - IW'(1));
          if (bram_last_n) begin
`ifdef DATA_BRAM_STREAMER_LOOP_EN
            if (loop_q) rd_idx_n = '0;
            else        state_n  = DRAIN;
`else
            state_n = DRAIN;
`endif
          end else begin
            rd_idx_n = rd_idx + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (pop && m_tlast) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      bram_last  <= 1'b0;
      rd_vld_sr  <= '0;
      rd_last_sr <= '0;
      rd_idx     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef DATA_BRAM_STREAMER_LOOP_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      bram_en       <= bram_en_n;
      bram_addr     <= bram_addr_n;
      bram_last     <= bram_last_n;
      // A read issued in the abort cycle is tagged invalid so its data is dropped.
      rd_vld_sr[0]  <= bram_en && !flush;
      rd_last_sr[0] <= bram_last;
      for (int i = 1; i < LAT; i++) begin
        rd_vld_sr[i]  <= rd_vld_sr[i-1] && !flush;
        rd_last_sr[i] <= rd_last_sr[i-1];
      end
      rd_idx <= rd_idx_n;
      done   <= done_n;
      busy   <= (state_n != IDLE);
      if (latch) begin
        base_q <= base_addr;
        len_q  <= length;
`ifdef DATA_BRAM_STREAMER_LOOP_EN
        loop_q <= loop_start;
`endif
      end
    end
  end

  data_bram_streamer_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk  (ACLK),
    .rst  (ARESET),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .din  ({rd_last_sr[LAT-1], bram_dout}),
    .head (head),
    .valid(m_tvalid),
    .count(fifo_count)
  );

  assign m_tdata = head[DATA_WIDTH-1:0];
  assign m_tlast = head[DATA_WIDTH];

endmodule

// File: tb/tb_data_bram_streamer.sv
// Scoreboard bench for data_bram_streamer: directed passes, wrap, backpressure,
// abort, zero length and mid-transfer reset.
module tb_data_bram_streamer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          loop_en = 1'b0;
  logic          m_tready = 1'b0;
  logic          busy, done, bram_en, m_tvalid, m_tlast;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] m_tdata;

  logic [DW-1:0] mem [1024];

  int            checks = 0;
  int            errors = 0;
  logic [DW:0]   sb [$];
  logic [DW:0]   exp_beat;
  logic [AW-1:0] addr_log [$];
  bit            log_en = 1'b0;
  bit            ahead_en = 1'b0;
  int            issued = 0;
  int            beats = 0;
  bit            stall_prev = 1'b0;
  bit            abort_prev = 1'b0;
  logic [DW:0]   prev_beat = '0;

  data_bram_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .length   (length),
    .loop_en  (loop_en),
    .busy     (busy),
    .done     (done),
    .bram_en  (bram_en),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  always #5 ACLK = ~ACLK;

  // One-cycle-latency BRAM read port.
  always @(posedge ACLK) if (bram_en) bram_dout <= mem[bram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop, stall stability and read-credit bound.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (stall_prev && !abort_prev) begin
        check("stall_valid_hold", 64'(m_tvalid), 64'd1);
        check("stall_data_hold", 64'({m_tlast, m_tdata}), 64'(prev_beat));
      end
      if (ahead_en && bram_en) begin
        issued++;
        check("read_credit", 64'((issued - beats) <= 4), 64'd1);
      end
      if (log_en && bram_en) addr_log.push_back(bram_addr);
      if (m_tvalid && m_tready) begin
        beats++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {m_tlast, m_tdata});
        end else begin
          exp_beat = sb.pop_front();
          check("beat", 64'({m_tlast, m_tdata}), 64'(exp_beat));
        end
      end
    end
    stall_prev = !ARESET && m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
    abort_prev = abort;
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_bram_en"}, 64'(bram_en), 64'd0);
    check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_tdata"}, 64'(m_tdata), 64'd0);
  endtask

  // Leaves the bench #1 into cycle 1, where cycle 0 carried start.
  task automatic do_start();
    @(posedge ACLK); #1;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic push_pass(input logic [AW-1:0] b, input int n, input int count);
    logic [AW-1:0] a;
    for (int k = 0; k < count; k++) begin
      a = b + AW'(k % n);
      sb.push_back({((k % n) == n - 1), mem[a]});
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge ACLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    check({tag, "_all_beats"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_pass(input logic [AW-1:0] b, input int n, input bit lp, input string tag);
    push_pass(b, n, n);
    base_addr = b;
    length    = (AW+1)'(n);
    loop_en   = lp;
    m_tready  = 1'b1;
    do_start();
    wait_done(n + 20, tag);
  endtask

  task automatic run_abort_case(input logic [AW-1:0] b, input int n, input bit lp, input int ac,
                                input string tag);
    push_pass(b, n, ac - 2);
    base_addr = b;
    length    = (AW+1)'(n);
    loop_en   = lp;
    m_tready  = 1'b1;
    do_start();
    for (int c = 1; c <= ac + 4; c++) begin
      abort = (c == ac);
      @(negedge ACLK);
      check({tag, "_tvalid"}, 64'(m_tvalid), 64'((c >= 3) && (c <= ac)));
      check({tag, "_no_done"}, 64'(done), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'(c <= ac));
      @(posedge ACLK); #1;
    end
    abort = 1'b0;
    check({tag, "_all_beats"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] exp_wrap [4];
    logic [AW-1:0] a;
    bit            seen;
    int            done_cnt;

    for (int i = 0; i < 1024; i++) mem[i] = (i < 4) ? DW'(i + 1) : (32'hC000_0000 | DW'(i));

    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Single pass, no backpressure: hand-computed cycle table.
    push_pass(10'h000, 4, 4);
    base_addr = 10'h000;
    length    = 11'd4;
    loop_en   = 1'b0;
    m_tready  = 1'b1;
    do_start();
    for (int c = 1; c <= 8; c++) begin
      @(negedge ACLK);
      check("t1_bram_en", 64'(bram_en), 64'((c >= 1) && (c <= 4)));
      if (c <= 4) check("t1_bram_addr", 64'(bram_addr), 64'(c - 1));
      check("t1_tvalid", 64'(m_tvalid), 64'((c >= 3) && (c <= 6)));
      check("t1_done", 64'(done), 64'(c == 7));
      check("t1_busy", 64'(busy), 64'((c >= 1) && (c <= 6)));
      if (c == 3) check("t1_first_data", 64'(m_tdata), 64'd1);
      if (c == 6) check("t1_last_beat", 64'({m_tlast, m_tdata}), 64'h1_0000_0004);
      @(posedge ACLK); #1;
    end
    check("t1_all_beats", 64'(sb.size()), 64'd0);

    // Address wrap past the top of the BRAM.
    exp_wrap = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    addr_log.delete();
    log_en = 1'b1;
    run_pass(10'h3FE, 4, 1'b0, "wrap");
    log_en = 1'b0;
    check("wrap_read_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size()) check("wrap_addr", 64'(addr_log[i]), 64'(exp_wrap[i]));

    // Random backpressure over 64 words.
    push_pass(10'h100, 64, 64);
    issued    = 0;
    beats     = 0;
    ahead_en  = 1'b1;
    base_addr = 10'h100;
    length    = 11'd64;
    loop_en   = 1'b0;
    do_start();
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge ACLK); #1;
      m_tready = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    ahead_en = 1'b0;
    m_tready = 1'b1;
    check("bp_done_seen", 64'(seen), 64'd1);
    check("bp_all_beats", 64'(sb.size()), 64'd0);
    check("bp_beat_count", 64'(beats), 64'd64);

`ifdef DATA_BRAM_STREAMER_LOOP_EN
    run_abort_case(10'h200, 3, 1'b1, 10, "loop_abort");
`else
    run_pass(10'h200, 3, 1'b1, "loop_ignored");
`endif
    run_abort_case(10'h200, 8, 1'b0, 5, "abort_run");
    run_abort_case(10'h200, 4, 1'b0, 6, "abort_final_beat");

    // Zero-length start.
    base_addr = 10'h050;
    length    = 11'd0;
    done_cnt  = 0;
    do_start();
    for (int c = 1; c <= 4; c++) begin
      @(negedge ACLK);
      check("zero_bram_en", 64'(bram_en), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_done", 64'(done), 64'(c == 1));
      if (done) done_cnt++;
      @(posedge ACLK); #1;
    end
    check("zero_done_pulses", 64'(done_cnt), 64'd1);

    // Reset during a stalled transfer with a full FIFO.
    m_tready  = 1'b0;
    issued    = 0;
    beats     = 0;
    ahead_en  = 1'b1;
    base_addr = 10'h300;
    length    = 11'd16;
    do_start();
    repeat (8) @(negedge ACLK);
    check("stall_tvalid", 64'(m_tvalid), 64'd1);
    check("stall_reads_issued", 64'(issued), 64'd4);
    a = 10'h300;
    check("stall_head", 64'({m_tlast, m_tdata}), 64'({1'b0, mem[a]}));
    @(posedge ACLK); #2;
    ARESET = 1'b1;
    #1;
    check_outputs_zero("midreset");
    ahead_en = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    run_pass(10'h340, 5, 1'b0, "after_reset");

    repeat (3) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
